imem_boot_loader: RTL and testbench
===================================

# imem_boot_loader

Boot-time controller that sequences the write port of `instruction_memory`. It accepts a program as a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words. It writes the words to consecutive word-aligned addresses starting at 0, and holds the CPU in reset until the requested number of words is loaded.

## Interface
- `DATA_WIDTH`, 32, instruction word width
- `BYTE_WIDTH`, 8, stream byte width
- `DIR_WIDTH`, 10, width of memory write address `dir` (byte address)
- `MEM_DEPTH`, 1024, memory size in bytes; capacity `MAX_WORDS = MEM_DEPTH/4` = 256
- `NW_WIDTH`, `$clog2(MAX_WORDS)+1` = 9, width of `num_words`

Ports. One clock; reset is synchronous and active-low.
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous active-low reset
- `start` in 1: one-cycle load request
- `num_words` in NW_WIDTH: words to load, sampled on accepted `start`
- `byte_valid` in 1: stream byte valid
- `byte_data` in BYTE_WIDTH: stream byte
- `byte_ready` out 1: loader accepts a byte this cycle
- `dir` out DIR_WIDTH: memory write byte address
- `data_in` out DATA_WIDTH: memory write data
- `we` out 1: memory write enable
- `busy` out 1: load in progress
- `done` out 1: load complete, sticky
- `error` out 1: bad `num_words`, sticky
- `cpu_rst_n` out 1: CPU reset release, high only when `done`

## Operation
- FSM states: IDLE, COLLECT, WRITE, DONE, ERR.
- **IDLE**
  - `start`=1 with `num_words` in 1..256: latch count, clear word index and byte lane → COLLECT.
  - `start`=1 with `num_words` 0 or >256 → ERR.
- **COLLECT**
  - `byte_ready`=1. Each `byte_valid && byte_ready` stores `byte_data` into lane `byte_cnt`; first byte goes to [7:0], fourth to [31:24].
  - Acceptance of the 4th byte → WRITE.
- **WRITE**
  - `byte_ready`=0, `we`=1 for exactly this cycle, `dir = word_idx*4`, `data_in` = packed word.
  - Last word (`word_idx == count-1`) → DONE; otherwise `word_idx++`, `byte_cnt=0` → COLLECT.
- **DONE**: `done`=1, `cpu_rst_n`=1.
- **ERR**: `error`=1, no writes, `cpu_rst_n`=0.
- Leaving DONE or ERR: `start` leaves DONE/ERR by the same rules as IDLE. `done`/`error` clear and `cpu_rst_n` drops the same cycle the new state is entered.
- `start` is ignored while `busy` (COLLECT/WRITE).
- `busy` = state ∈ {COLLECT, WRITE}.
- Bytes are never dropped. `byte_valid` without `byte_ready` is held off by the source.
- `dir` wraps never: the count check guarantees `word_idx*4 ≤ 1020`.

## Timing
- Reset values: state IDLE, `byte_ready`=0, `we`=0, `dir`=0, `data_in`=0, `busy`=0, `done`=0, `error`=0, `cpu_rst_n`=0. Internal counters are 0.
- `we`, `dir` and `data_in` are registered. If the 4th byte is accepted at edge N, `we` is high from N to N+1, and memory captures at N+1.
- `byte_ready` is a function of registered state only; there is no combinational path from `byte_valid`.
- Peak throughput is 5 cycles per word: 4 byte cycles plus 1 write cycle.
- `done` and `cpu_rst_n` rise at the edge after the last WRITE cycle.
- `start` to first `byte_ready`=1 takes 1 cycle.
- Reset mid-load aborts immediately. No `we` occurs in the cycle after `rst_n` sampled low, partial words are discarded, and the next load restarts at `dir`=0.
- `rst_n` low has priority over `start` in the same cycle.

## Structure
- Package `imem_boot_pkg`:
  - state enum `boot_state_t`
  - constants `MAX_WORDS` and `WORD_BYTES` = 4
  - localparam widths shared with `instruction_memory` (DATA/BYTE/DIR widths)
- Sub-module `imem_word_packer`:
  - byte lane counter plus shift/insert register
  - inputs: accept strobe, byte, clear
  - outputs: word, `word_full`
- The FSM, word index and count check stay in the top module.

## Test plan
- **Reset**: hold `rst_n`=0 for 2 cycles with `byte_valid`=1 → all outputs at reset values, no `we`.
- **Fibonacci load**:
  - Stimulus: `num_words`=10; stream the 40 bytes LSB-first for 00000513, 00100593, 00A00613, 00060C63, 00B502B3, 00B00533, 005005B3, FFF60613, FEDFF06F, 0000006F.
  - Required: exactly 10 `we` pulses at `dir` 0,4,…,36 carrying those words, then `done`=`cpu_rst_n`=1.
  - Memory read back at `a`=36 → 0000006F.
- **Stalled stream**: same program with `byte_valid` deasserted randomly (including mid-word) → identical write sequence, no duplicated or dropped bytes.
- **Bad count**: `num_words`=0 and `num_words`=257 → `error`=1, `busy`=0, zero `we` pulses. A following valid `start` clears `error`.
- **Reset mid-load**: assert `rst_n`=0 after 6 accepted bytes → only `dir`=0 was written (00000513). A fresh load of 2 words writes `dir` 0 and 4.
- **Restart behaviour**:
  - `start` pulsed during COLLECT → ignored, count unchanged.
  - `start` in DONE → `cpu_rst_n` drops the same cycle and a new load begins at `dir`=0.

Source files
------------

// File: rtl/imem_boot_pkg.sv
// Shared types and sizes for the instruction-memory boot loader.
// Widths match the write port of instruction_memory.
package imem_boot_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned BYTE_WIDTH = 8;
  localparam int unsigned DIR_WIDTH  = 10;
  localparam int unsigned MEM_DEPTH  = 1024;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned MAX_WORDS  = MEM_DEPTH / WORD_BYTES;
  localparam int unsigned NW_WIDTH   = $clog2(MAX_WORDS) + 1;
  localparam int unsigned IDX_WIDTH  = $clog2(MAX_WORDS);
  localparam int unsigned LANE_WIDTH = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WRITE,
    ST_DONE,
    ST_ERR
  } boot_state_t;

  // A load request is legal for 1..MAX_WORDS words.
  function automatic logic count_ok(input logic [NW_WIDTH-1:0] n);
    return (n != '0) && (n <= NW_WIDTH'(MAX_WORDS));
  endfunction

endpackage

// File: rtl/imem_word_packer.sv
// Packs accepted stream bytes little-endian into one word.
// Ports: clk, rst_n (sync, active-low), clear (restart at lane 0),
//        accept (byte handshake strobe), byte_data,
//        word (registered packed word), word_full_c (this accept completes a word).
module imem_word_packer
  import imem_boot_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  accept,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full_c
);

  logic [LANE_WIDTH-1:0] lane_q;

  assign word_full_c = accept && (lane_q == LANE_WIDTH'(WORD_BYTES - 1));

  // Lane counter wraps naturally after the top byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lane_q <= '0;
      word   <= '0;
    end else if (clear) begin
      lane_q <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        if (lane_q == LANE_WIDTH'(i)) begin
          word[i*BYTE_WIDTH +: BYTE_WIDTH] <= byte_data;
        end
      end
      lane_q <= lane_q + LANE_WIDTH'(1);
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams a program into instruction memory and holds the
// CPU in reset until the requested number of words has been written.
// Ports: clk, rst_n (sync, active-low), start, num_words,
//        byte_valid/byte_data/byte_ready (byte stream),
//        dir/data_in/we (memory write port), busy, done, error, cpu_rst_n.
module imem_boot_loader
  import imem_boot_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NW_WIDTH-1:0]   num_words,
  input  logic                  byte_valid,
  input  logic [BYTE_WIDTH-1:0] byte_data,
  output logic                  byte_ready,
  output logic [DIR_WIDTH-1:0]  dir,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  we,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  cpu_rst_n
);

  boot_state_t          state_q, state_d;
  logic [NW_WIDTH-1:0]  count_q;
  logic [IDX_WIDTH-1:0] word_idx_q;
  logic                 load_c;
  logic                 clear_c;
  logic                 accept_c;
  logic                 word_full_c;
  logic                 last_word_c;

  assign accept_c    = byte_valid && byte_ready;
  assign last_word_c = (NW_WIDTH'(word_idx_q) == (count_q - NW_WIDTH'(1)));

  imem_word_packer u_packer (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear_c),
    .accept      (accept_c),
    .byte_data   (byte_data),
    .word        (data_in),
    .word_full_c (word_full_c)
  );

  // Next-state logic; DONE and ERR accept a new start like IDLE.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    clear_c = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          if (count_ok(num_words)) begin
            state_d = ST_COLLECT;
            load_c  = 1'b1;
            clear_c = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_COLLECT: begin
        if (word_full_c) state_d = ST_WRITE;
      end
      ST_WRITE: begin
        clear_c = 1'b1;
        state_d = last_word_c ? ST_DONE : ST_COLLECT;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and registered outputs (decoded from next state).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      word_idx_q <= '0;
      byte_ready <= 1'b0;
      we         <= 1'b0;
      dir        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_rst_n  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_c) begin
        count_q    <= num_words;
        word_idx_q <= '0;
      end else if ((state_q == ST_WRITE) && !last_word_c) begin
        word_idx_q <= word_idx_q + IDX_WIDTH'(1);
      end
      if (state_d == ST_WRITE) dir <= DIR_WIDTH'({word_idx_q, 2'b00});
      byte_ready <= (state_d == ST_COLLECT);
      we         <= (state_d == ST_WRITE);
      busy       <= (state_d == ST_COLLECT) || (state_d == ST_WRITE);
      done       <= (state_d == ST_DONE);
      error      <= (state_d == ST_ERR);
      cpu_rst_n  <= (state_d == ST_DONE);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader with a write-port memory model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [8:0]  num_words;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [9:0]  dir;
  logic [31:0] data_in;
  logic        we;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prog [10];
  logic [31:0] mem  [256];
  logic [9:0]  log_dir [64];
  logic [31:0] log_dat [64];
  int          n_wr = 0;

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .num_words  (num_words),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .dir        (dir),
    .data_in    (data_in),
    .we         (we),
    .busy       (busy),
    .done       (done),
    .error      (error),
    .cpu_rst_n  (cpu_rst_n)
  );

  // Write-port model: each we pulse lasts one cycle, logged once at negedge.
  always @(negedge clk) begin
    if (we === 1'b1) begin
      if (n_wr < 64) begin
        log_dir[n_wr] = dir;
        log_dat[n_wr] = data_in;
      end
      mem[dir[9:2]] = data_in;
      n_wr = n_wr + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic pulse_start(input logic [8:0] n);
    start     = 1'b1;
    num_words = n;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Offer one byte after `gap` idle cycles; returns one cycle-step after acceptance.
  task automatic send_byte(input logic [7:0] b, input int gap);
    logic acc;
    byte_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    acc = 1'b0;
    for (int t = 0; t < 100 && !acc; t++) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk);
      #1;
    end
    byte_valid = 1'b0;
    if (!acc) check("byte_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_prog(input int nbytes, input int max_gap);
    logic [31:0] w;
    for (int i = 0; i < nbytes; i++) begin
      w = prog[i/4];
      send_byte(8'(w >> (8 * (i % 4))), (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0);
    end
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 30 && !seen; t++) begin
      @(negedge clk);
      seen = done;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic verify_writes(input string tag, input int n_exp);
    check({tag, "_count"}, 32'(n_wr), 32'(n_exp));
    for (int i = 0; i < n_exp && i < n_wr; i++) begin
      check({tag, "_dir"},  32'(log_dir[i]), 32'(i * 4));
      check({tag, "_data"}, log_dat[i], prog[i]);
    end
  endtask

  initial begin
    prog[0] = 32'h00000513; prog[1] = 32'h00100593; prog[2] = 32'h00A00613;
    prog[3] = 32'h00060C63; prog[4] = 32'h00B502B3; prog[5] = 32'h00B00533;
    prog[6] = 32'h005005B3; prog[7] = 32'hFFF60613; prog[8] = 32'hFEDFF06F;
    prog[9] = 32'h0000006F;

    rst_n      = 1'b0;
    start      = 1'b0;
    num_words  = '0;
    byte_valid = 1'b1;
    byte_data  = 8'hAA;

    // Reset with a byte offered: everything at reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_we",         32'(we),         32'd0);
    check("rst_dir",        32'(dir),        32'd0);
    check("rst_data_in",    data_in,         32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_error",      32'(error),      32'd0);
    check("rst_cpu_rst_n",  32'(cpu_rst_n),  32'd0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    byte_valid = 1'b0;
    check("rst_no_writes", 32'(n_wr), 32'd0);

    // Fibonacci load, unstalled stream.
    n_wr = 0;
    pulse_start(9'd10);
    check("start_ready_1cyc", 32'(byte_ready), 32'd1);
    check("start_busy",       32'(busy),       32'd1);
    send_prog(40, 0);
    wait_done();
    verify_writes("fib", 10);
    check("fib_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    check("fib_busy",      32'(busy),      32'd0);
    check("fib_mem36",     mem[9],         32'h0000006F);

    // Start in DONE: CPU reset drops immediately, then a stalled reload
    // with an ignored start pulse mid-collect.
    n_wr = 0;
    pulse_start(9'd10);
    check("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("restart_done",      32'(done),      32'd0);
    check("restart_busy",      32'(busy),      32'd1);
    send_prog(6, 3);
    pulse_start(9'd1);
    check("ignored_start_busy", 32'(busy), 32'd1);
    for (int i = 6; i < 40; i++) begin
      send_byte(8'(prog[i/4] >> (8 * (i % 4))), int'($urandom_range(3, 0)));
    end
    wait_done();
    verify_writes("stall", 10);

    // Bad counts: error, no writes; a valid start clears error.
    n_wr = 0;
    pulse_start(9'd0);
    check("bad0_error", 32'(error), 32'd1);
    check("bad0_busy",  32'(busy),  32'd0);
    check("bad0_done",  32'(done),  32'd0);
    check("bad0_cpu",   32'(cpu_rst_n), 32'd0);
    pulse_start(9'd257);
    repeat (3) @(posedge clk);
    #1;
    check("bad257_error",  32'(error), 32'd1);
    check("bad257_busy",   32'(busy),  32'd0);
    check("bad_no_writes", 32'(n_wr),  32'd0);
    pulse_start(9'd10);
    check("err_cleared", 32'(error), 32'd0);
    check("err_busy",    32'(busy),  32'd1);

    // Reset after 6 accepted bytes: only dir 0 written.
    send_prog(6, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_we",    32'(we),         32'd0);
    check("midrst_busy",  32'(busy),       32'd0);
    check("midrst_ready", 32'(byte_ready), 32'd0);
    rst_n = 1'b1;
    verify_writes("midrst", 1);

    // Fresh 2-word load restarts at dir 0.
    n_wr = 0;
    pulse_start(9'd2);
    send_prog(8, 0);
    wait_done();
    verify_writes("fresh", 2);
    check("fresh_cpu_rst_n", 32'(cpu_rst_n), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
